// File: rtl/rca4_serial_ctrl.sv
// rca4_serial_ctrl: digit-serial add/sub built on one shared 4-bit
// ripple-carry adder, computing one nibble slice per clock.
//
// Ports:
//   clk, rst_n   clock, async active-low reset
//   start        request a new operation (IDLE only)
//   sub          1 = a-b, 0 = a+b (sampled with start)
//   a, b         W-bit operands (sampled with start)
//   busy         high while slices are computed
//   done         one-cycle completion pulse
//   sum          result register
//   c_out        final carry (sub: 1 = no borrow)
//   ovf          two's-complement overflow

module rca4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       c_out
);

  logic [4:0] c;

  assign c[0] = c_in;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i])
                  | (c[i] & (a[i] ^ b[i]));
  end

  assign c_out = c[4];

endmodule

module rca4_serial_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 sub,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 c_out,
  output logic                 ovf
);

  localparam int W  = 4 * NIBBLES;
  localparam int KW = (NIBBLES > 1)
                    ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  sum_q;
  logic          sub_q;
  logic          cy_q;
  logic          c_out_q;
  logic          ovf_q;
  logic [KW-1:0] k_q;

  logic          accept;
  logic          step;
  logic          last;
  logic [KW+1:0] base;
  logic [3:0]    sl_a;
  logic [3:0]    sl_b;
  logic [3:0]    sl_s;
  logic          sl_c;
  logic          bp_msb;
  logic          ovf_d;

  assign accept = (state_q == IDLE) & start;
  assign step   = (state_q == RUN);
  assign last   = (k_q == KW'(NIBBLES - 1));
  assign base   = {k_q, 2'b00};

  assign sl_a = a_q[base +: 4];
  assign sl_b = b_q[base +: 4] ^ {4{sub_q}};

  rca4 u_rca4 (
    .a     (sl_a),
    .b     (sl_b),
    .c_in  (cy_q),
    .s     (sl_s),
    .c_out (sl_c)
  );

  // sl_s[3] is the result MSB on the last slice
  assign bp_msb = b_q[W-1] ^ sub_q;
  assign ovf_d  = (a_q[W-1] == bp_msb)
                & (sl_s[3] != a_q[W-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (last)  state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      cy_q    <= 1'b0;
      k_q     <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      sub_q   <= sub;
      cy_q    <= sub;
      k_q     <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (step) begin
      sum_q[base +: 4] <= sl_s;
      cy_q             <= sl_c;
      k_q              <= k_q + KW'(1);
      if (last) begin
        c_out_q <= sl_c;
        ovf_q   <= ovf_d;
      end
    end
  end

  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_rca4_serial_ctrl.sv
// tb_rca4_serial_ctrl: directed checks of the serial add/sub
// controller with NIBBLES=4.

module tb_rca4_serial_ctrl;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;

  int checks;
  int errors;

  rca4_serial_ctrl #(.NIBBLES(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h",
             tag, got, exp);
    end
  endtask

  task automatic do_op(
    input string        tag,
    input logic [W-1:0] ai,
    input logic [W-1:0] bi,
    input logic         si,
    input logic [W-1:0] es,
    input logic         ec,
    input logic         eo
  );
    int n;
    int bc;
    @(negedge clk);
    a = ai; b = bi; sub = si;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    bc = 0;
    while (!done && n < 20) begin
      if (busy) bc++;
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, n, N + 1);
    chk({tag, "_busy"}, bc, N);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_c"}, c_out, ec);
    chk({tag, "_ovf"}, ovf, eo);
    @(negedge clk);
    chk({tag, "_pulse"}, done, 0);
    chk({tag, "_hold"}, sum, es);
  endtask

  initial begin
    int dn;
    int idx[$];
    checks = 0;
    errors = 0;
    rst_n = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_c", c_out, 0);
    chk("rst_ovf", ovf, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("add1", 16'h1234, 16'h0FCC, 0,
          16'h2200, 0, 0);
    do_op("addc", 16'hFFFF, 16'h0001, 0,
          16'h0000, 1, 0);
    do_op("addv", 16'h7FFF, 16'h0001, 0,
          16'h8000, 0, 1);
    do_op("subn", 16'h0005, 16'h0007, 1,
          16'hFFFE, 0, 0);
    do_op("subv", 16'h8000, 16'h0001, 1,
          16'h7FFF, 1, 1);
    do_op("addx", 16'hA5A5, 16'h5A5A, 0,
          16'hFFFF, 0, 0);
    do_op("subz", 16'h1234, 16'h1234, 1,
          16'h0000, 1, 0);

    // start + operand change in RUN cycle 2
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; sub = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    a = 16'hFFFF; b = 16'hFFFF; sub = 1;
    dn = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        dn++;
        chk("ign_sum", sum, 16'h3333);
        chk("ign_c", c_out, 0);
      end
    end
    chk("ign_ndone", dn, 1);
    chk("ign_idle", busy, 0);

    // async reset mid-operation
    @(negedge clk);
    a = 16'h4444; b = 16'h1111; sub = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("mid_busy", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_done", done, 0);
    chk("ar_sum", sum, 0);
    chk("ar_c", c_out, 0);
    chk("ar_ovf", ovf, 0);
    dn = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("ar_nodone", dn, 0);
    do_op("post", 16'h0001, 16'h0001, 0,
          16'h0002, 0, 0);

    // start held high for 20 cycles
    @(negedge clk);
    a = 16'h0010; b = 16'h0020; sub = 0;
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) idx.push_back(i);
    end
    start = 1'b0;
    chk("b2b_cnt", idx.size(), 3);
    for (int i = 1; i < idx.size(); i++)
      chk("b2b_gap", idx[i] - idx[i-1], 6);
    for (int i = 0; i < 8; i++)
      @(negedge clk);
    chk("b2b_sum", sum, 16'h0030);
    chk("b2b_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/rca4_serial_ctrl.md
RCA4_SERIAL_CTRL -- requirements
Module: rca4_serial_ctrl

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, giving the number of 4-bit slices per operand; W = 4*NIBBLES; legal range 2..8.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, request for a new operation.
REQ-005 The block SHALL have port sub, input, 1, selecting subtract (a-b) when 1 and add (a+b) when 0; sampled with start.
REQ-006 The block SHALL have ports a and b, input, W each, the operands; sampled with start.
REQ-007 The block SHALL have port busy, output, 1, high while slices are being computed.
REQ-008 The block SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-009 The block SHALL have port sum, output, W, the result register.
REQ-010 The block SHALL have port c_out, output, 1, the final carry (for sub: 1 = no borrow).
REQ-011 The block SHALL have port ovf, output, 1, the two's-complement signed overflow flag.

Function
REQ-012 The datapath SHALL contain exactly one instance of the team's 4-bit ripple-carry adder RCA4, time-shared over all slices; no other adder SHALL exist.
REQ-013 The FSM SHALL have states IDLE, RUN and DONE.
REQ-014 IDLE: on a clock edge with start=1, the block SHALL latch a, b and sub, clear the slice index to 0, load the carry register with sub, clear sum to 0, and go to RUN; start=0 keeps IDLE.
REQ-015 RUN: each edge SHALL drive RCA4 with a-slice k, b-slice k XOR {4{sub}} and the carry register, write the RCA4 sum into sum[4k+3:4k], load RCA4 c_out into the carry register, and increment k.
REQ-016 The edge that writes slice NIBBLES-1 SHALL move the FSM to DONE; c_out SHALL then equal the final carry register.
REQ-017 DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-018 busy SHALL equal (state==RUN); done SHALL equal (state==DONE); both are registered-state decodes with no combinational path from start.
REQ-019 Latency: start accepted at edge E0 SHALL give busy=1 from E0 to E(NIBBLES), and done=1 for the single cycle following E(NIBBLES).
REQ-020 ovf SHALL be set at the final RUN edge to (a[W-1] == b'[W-1]) AND (sum[W-1] != a[W-1]), where b' = b XOR {W{sub}}.
REQ-021 sum, c_out and ovf SHALL hold their values from DONE until the next accepted start.
REQ-022 start asserted during RUN or DONE SHALL be ignored, with no queuing; a, b and sub changes during RUN SHALL have no effect.
REQ-023 Carry wrap: the carry out of slice NIBBLES-1 SHALL NOT feed any later slice; it SHALL appear only on c_out.
REQ-024 Back-to-back: start held high continuously SHALL produce one operation every NIBBLES+2 cycles.

Reset
REQ-025 rst_n=0 SHALL immediately force state IDLE, k=0, carry register=0, sum=0, c_out=0, ovf=0, busy=0 and done=0, independent of clk.
REQ-026 Reset during RUN or DONE SHALL discard the operation with no done pulse; the first start after rst_n deasserts SHALL be processed normally.

Verification
REQ-027 With NIBBLES=4, add 0x1234+0x0FCC SHALL give sum=0x2200, c_out=0, ovf=0; busy high for 4 cycles; done pulse 4 edges after the accept edge.
REQ-028 Add 0xFFFF+0x0001 SHALL give sum=0x0000, c_out=1, ovf=0; add 0x7FFF+0x0001 SHALL give sum=0x8000, c_out=0, ovf=1.
REQ-029 Sub 0x0005-0x0007 SHALL give sum=0xFFFE, c_out=0, ovf=0; sub 0x8000-0x0001 SHALL give sum=0x7FFF, c_out=1, ovf=1.
REQ-030 A start pulse plus operand change in RUN cycle 2 SHALL leave the result unchanged, produce exactly one done pulse, and accept no second operation.
REQ-031 rst_n low in RUN cycle 2 SHALL make all outputs 0 asynchronously with no done pulse; a following add 0x0001+0x0001 SHALL give sum=0x0002.
REQ-032 start held high for 20 cycles SHALL produce done pulses exactly 6 cycles apart.
